// File: rtl/div_unit_if.sv
// Pipeline-to-divider handshake: EX issues the divide, the divider answers
// with busy/stall/done and the registered result.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  flush;
  logic                  busy;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/div_unit.sv
// RV32M restoring divider, one quotient bit per cycle, with single-cycle
// handling of divide-by-zero and signed overflow.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic     clk,
  input logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  neg_q_q, neg_r_q, rem_op_q;

  logic                  is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [DATA_WIDTH-1:0] a_abs, b_abs, special_res;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic                  ge, last;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt, q_fix, r_fix, final_res;
  logic                  busy_c, stall_c, done_c, accept;

  // Operand conditioning in IDLE: magnitudes for signed ops and early-out detection
  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.a[DATA_WIDTH-1];
    b_neg     = is_signed & bus.b[DATA_WIDTH-1];
    a_abs     = a_neg ? -bus.a : bus.a;
    b_abs     = b_neg ? -bus.b : bus.b;
    div_zero  = (bus.b == '0);
    overflow  = is_signed && (bus.a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (bus.b == '1);
    special   = div_zero | overflow;
    if (div_zero)
      special_res = bus.op[1] ? bus.a : '1;
    else
      special_res = bus.op[1] ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  // One restoring step; the extra subtractor bit acts as the borrow flag
  always_comb begin
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dvsr_q};
    ge        = ~diff[DATA_WIDTH];
    rem_nxt   = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_nxt   = {quo_q[DATA_WIDTH-2:0], ge};
    q_fix     = neg_q_q ? -quo_nxt : quo_nxt;
    r_fix     = neg_r_q ? -rem_nxt : rem_nxt;
    final_res = rem_op_q ? r_fix : q_fix;
    last      = (cnt_q == CNT_WIDTH'(DATA_WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush always wins over start and silences a pending done
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    stall_c   = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept    = 1'b1;
          stall_c   = 1'b1;
          state_nxt = special ? DONE : RUN;
        end
      end
      RUN: begin
        busy_c  = 1'b1;
        stall_c = 1'b1;
        if (bus.flush)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: begin
        done_c    = ~bus.flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rem_op_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rem_q    <= '0;
        quo_q    <= a_abs;
        dvsr_q   <= b_abs;
        cnt_q    <= '0;
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= a_neg;
        rem_op_q <= bus.op[1];
        if (special) result_q <= special_res;
      end else if (state == RUN && !bus.flush) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (last) result_q <= final_res;
      end
    end
  end

  assign bus.busy   = busy_c;
  assign bus.stall  = stall_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle RV32M divider in the EX stage, one bit per cycle. Its registered result feeds the EX result-select 2:1 mux as the data input chosen for DIV/DIVU/REM/REMU instructions. While a division is running it stalls the pipeline so the instruction holds in EX. The mux then forwards `result` on the cycle `done` is high.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a divide instruction; sampled only in IDLE.
- op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  DATA_WIDTH  dividend (rs1).
- b  input  DATA_WIDTH  divisor (rs2).
- flush  input  1  branch or exception kill; aborts any operation in progress.
- busy  output  1  high while in RUN.
- stall  output  1  combinational freeze request to the PC/IF/ID/EX registers.
- done  output  1  one-cycle pulse; `result` is valid in that cycle.
- result  output  DATA_WIDTH  registered quotient or remainder.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset:
  - Synchronous reset applies on any clk edge with rst=1, in any state, including mid-RUN.
  - After reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal partial remainder and quotient=0.
- IDLE:
  - On an edge with start=1 and flush=0, capture the operands.
  - For signed ops (DIV/REM) take |a| and |b|. Record neg_q = a[31]^b[31] and neg_r = a[31].
  - Go to DONE next if a special case applies, else go to RUN with counter=0.
  - start=0 or flush=1: remain in IDLE.
- Special cases resolve in one cycle with no iteration:
  - b==0: quotient = all ones (0xFFFFFFFF for both DIV and DIVU); remainder = a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- RUN:
  - Each cycle performs one restoring step: shift the remainder left and bring in the next dividend MSB.
  - If the shifted remainder is >= |b|, subtract |b| and shift quotient bit 1 in; otherwise shift 0 in.
  - The subtraction is DATA_WIDTH+1 bits wide so no carry is lost.
  - counter increments every cycle. After the step with counter==DATA_WIDTH-1, go to DONE.
  - This gives exactly DATA_WIDTH (32) RUN cycles.
- DONE:
  - done=1 for exactly one cycle.
  - result is loaded on the edge entering DONE: quotient (DIV/DIVU) or remainder (REM/REMU).
  - Sign fix-up for signed ops: negate the quotient if neg_q; negate the remainder if neg_r.
  - Next state is always IDLE.
  - result holds its value until the next completion or reset.
- Latency:
  - start sampled at edge T. Normal op: RUN for cycles T+1..T+32, DONE at T+33.
  - Special case: DONE at T+1.
- stall = (IDLE & start & ~flush) | RUN. stall is 0 in DONE so the pipeline advances in the same cycle the mux consumes `result`.
- busy = (state==RUN).
- start while in RUN or DONE is ignored. There is no queueing, and the operands latched at start are used unchanged.
- flush in RUN or DONE: next state is IDLE, done stays 0 (a pending done is suppressed), and result is not updated.
- flush takes priority over start in the same cycle.
- rst takes priority over flush and start.

Test Plan:
- DIVU a=100, b=7 -> done exactly 33 cycles after the start edge; result=14; stall high for 33 cycles, low on the done cycle. REMU with the same operands -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> result=0xFFFFFFFF (-1). REM a=7, b=-2 -> result=1.
- Divide by zero: DIVU a=5, b=0 -> result=0xFFFFFFFF with done at T+1. REM a=0x80000001, b=0 -> result=0x80000001.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 at T+1. REM with the same operands -> result=0.
- Flush at RUN cycle 10 -> IDLE next cycle, done never pulses, result keeps its previous value (14). A following start with DIVU 9/3 -> result=3 after 33 cycles.
- Reset mid-RUN (cycle 20) -> the next cycle shows IDLE, busy=0, stall=0, done=0, result=0. A start pulse asserted during RUN is ignored: only one done pulse occurs.
